cmos_pixel_capture: RTL and testbench

CMOS_PIXEL_CAPTURE -- requirements
Module: cmos_pixel_capture

---
 rtl/cmos_capture_pkg.sv | 28 ++
 rtl/cmos_sync.sv | 29 ++
 rtl/cmos_pixel_capture.sv | 198 +++++++++++++++++++
 tb/tb_cmos_pixel_capture.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cmos_capture_pkg.sv
// Shared types and constants for the CMOS pixel capture block.
package cmos_capture_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_VS   = 2'd1,
    ACTIVE    = 2'd2,
    FRAME_END = 2'd3
  } cap_state_e;

  // Flag positions above the pixel field in fifo_data.
  localparam int SOL_BIT = 0;
  localparam int SOF_BIT = 1;

  localparam int BPP_MIN   = 1;
  localparam int BPP_MAX   = 4;
  localparam int DECIM_MIN = 1;
  localparam int DECIM_MAX = 16;

  localparam int POS_W = 16;

  function automatic logic in_range(input logic [POS_W-1:0] v,
                                    input logic [POS_W-1:0] lo,
                                    input logic [POS_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/cmos_sync.sv
// Two-flop synchronizer with rise/fall detect on the first two stages.
module cmos_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] s1, s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q    = s1;
  assign rise = s1 & ~s2;
  assign fall = ~s1 & s2;

endmodule

// File: rtl/cmos_pixel_capture.sv
// Captures a DVP-style camera stream into a FIFO with windowing, decimation
// and start-of-frame / start-of-line tagging.
module cmos_pixel_capture
  import cmos_capture_pkg::*;
#(
  parameter int DB_W          = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int H_DECIM       = 1,
  parameter int V_DECIM       = 1,
  parameter int X0            = 0,
  parameter int X1            = 639,
  parameter int Y0            = 0,
  parameter int Y1            = 479,
  parameter int CNT_W         = 16
) (
  input  logic                            clk_100,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            cmos_pclk,
  input  logic                            cmos_href,
  input  logic                            cmos_vsync,
  input  logic [DB_W-1:0]                 cmos_db,
  input  logic                            fifo_full,
  output logic                            fifo_wr,
  output logic [DB_W*BYTES_PER_PIX+1:0]   fifo_data,
  output logic                            frame_done,
  output logic [CNT_W-1:0]                frame_count,
  output logic [CNT_W-1:0]                drop_count,
  output logic                            busy
);

  localparam int PIX_W = DB_W * BYTES_PER_PIX;
  localparam int SW    = DB_W + 3;

  localparam logic [1:0]       BEAT_LAST = 2'(BYTES_PER_PIX - 1);
  localparam logic [3:0]       HD_LAST   = 4'(H_DECIM - 1);
  localparam logic [3:0]       VD_LAST   = 4'(V_DECIM - 1);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [POS_W-1:0] X0_C = POS_W'(X0);
  localparam logic [POS_W-1:0] X1_C = POS_W'(X1);
  localparam logic [POS_W-1:0] Y0_C = POS_W'(Y0);
  localparam logic [POS_W-1:0] Y1_C = POS_W'(Y1);

  logic [SW-1:0] sq, srise, sfall;

  cmos_sync #(.W(SW)) u_sync (
    .clk  (clk_100),
    .rst_n(rst_n),
    .d    ({cmos_pclk, cmos_href, cmos_vsync, cmos_db}),
    .q    (sq),
    .rise (srise),
    .fall (sfall)
  );

  logic            pclk_rise, href_q, href_fall, vs_rise, vs_fall;
  logic [DB_W-1:0] db_q;
  logic            unused_sync;

  assign pclk_rise   = srise[SW-1];
  assign href_q      = sq[SW-2];
  assign href_fall   = sfall[SW-2];
  assign vs_rise     = srise[SW-3];
  assign vs_fall     = sfall[SW-3];
  assign db_q        = sq[DB_W-1:0];
  assign unused_sync = ^{sq[SW-1], sq[SW-3], srise[SW-2], srise[DB_W-1:0],
                         sfall[SW-1], sfall[DB_W-1:0]};

  cap_state_e state, state_nxt;
  logic       end_pend;
  logic       in_frame, frame_start, take, pix_done, keep;

  logic [1:0]       beat;
  logic [POS_W-1:0] col, line;
  logic [3:0]       hdec, vdec;
  logic [PIX_W-1:0] pix_acc, pix_shift, pix_reg;
  logic             wr_pend, sof_pend, sol_pend;

  assign in_frame    = (state == ACTIVE);
  assign frame_start = (state == WAIT_VS) && enable && vs_fall;
  assign take        = in_frame && pclk_rise && href_q;
  assign pix_done    = take && (beat == BEAT_LAST);
  assign keep        = in_range(col, X0_C, X1_C) && in_range(line, Y0_C, Y1_C) &&
                       (hdec == 4'd0) && (vdec == 4'd0);

  // First beat ends up in the top DB_W bits after BYTES_PER_PIX shifts.
  generate
    if (BYTES_PER_PIX == 1) begin : g_one
      assign pix_shift = db_q;
    end else begin : g_multi
      assign pix_shift = {pix_acc[PIX_W-DB_W-1:0], db_q};
    end
  endgenerate

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A pixel completing alongside the vsync rise is written before FRAME_END.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (enable) state_nxt = WAIT_VS;
      WAIT_VS:   if (!enable) state_nxt = IDLE;
                 else if (vs_fall) state_nxt = ACTIVE;
      ACTIVE:    if ((vs_rise || end_pend) && !pix_done) state_nxt = FRAME_END;
      FRAME_END: state_nxt = enable ? WAIT_VS : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n)                   end_pend <= 1'b0;
    else if (!in_frame)           end_pend <= 1'b0;
    else if (vs_rise && pix_done) end_pend <= 1'b1;
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      beat    <= '0;
      col     <= '0;
      line    <= '0;
      hdec    <= '0;
      vdec    <= '0;
      pix_acc <= '0;
    end else if (frame_start) begin
      beat <= '0;
      col  <= '0;
      line <= '0;
      hdec <= '0;
      vdec <= '0;
    end else if (in_frame) begin
      if (take) begin
        pix_acc <= pix_shift;
        beat    <= pix_done ? 2'd0 : beat + 2'd1;
      end
      if (pix_done) begin
        col  <= (col == '1) ? col : col + POS_ONE;
        hdec <= (hdec == HD_LAST) ? 4'd0 : hdec + 4'd1;
      end
      // A line end drops any partial pixel and restarts column tracking.
      if (href_fall) begin
        beat <= '0;
        col  <= '0;
        hdec <= '0;
        line <= (line == '1) ? line : line + POS_ONE;
        vdec <= (vdec == VD_LAST) ? 4'd0 : vdec + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend <= 1'b0;
      pix_reg <= '0;
    end else begin
      wr_pend <= pix_done && keep;
      if (pix_done) pix_reg <= pix_shift;
    end
  end

  assign fifo_wr = wr_pend && !fifo_full;

  // Tags stay armed until a pixel actually reaches the FIFO.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      sof_pend <= 1'b0;
      sol_pend <= 1'b0;
    end else begin
      if (frame_start)  sof_pend <= 1'b1;
      else if (fifo_wr) sof_pend <= 1'b0;
      if (frame_start || (in_frame && href_fall)) sol_pend <= 1'b1;
      else if (fifo_wr)                           sol_pend <= 1'b0;
    end
  end

  always_comb begin
    fifo_data                   = '0;
    fifo_data[PIX_W-1:0]        = pix_reg;
    fifo_data[PIX_W + SOF_BIT]  = sof_pend;
    fifo_data[PIX_W + SOL_BIT]  = sol_pend;
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      drop_count  <= '0;
      frame_count <= '0;
    end else begin
      if (wr_pend && fifo_full && (drop_count != '1)) drop_count <= drop_count + CNT_ONE;
      if (state == FRAME_END) frame_count <= frame_count + CNT_ONE;
    end
  end

  assign frame_done = (state == FRAME_END);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_cmos_pixel_capture.sv
// Directed bench: default instance plus a 2x2-decimating instance on shared stimulus.
module tb_cmos_pixel_capture;

  logic        clk_100 = 1'b0;
  logic        rst_n, enable, cmos_pclk, cmos_href, cmos_vsync, fifo_full;
  logic [7:0]  cmos_db;

  logic        fifo_wr0, frame_done0, busy0;
  logic [17:0] fifo_data0;
  logic [15:0] frame_count0, drop_count0;
  logic        fifo_wr1, frame_done1, busy1;
  logic [17:0] fifo_data1;
  logic [15:0] frame_count1, drop_count1;

  int checks = 0;
  int errors = 0;
  int cyc = 0, nw0 = 0, nw1 = 0, fd0 = 0, fd_cyc = -10, bf_cyc = -20;
  int base0, base1, fdb;
  logic busy_prev = 1'b0;
  logic [17:0] w0 [0:255];
  logic [17:0] w1 [0:255];

  cmos_pixel_capture u0 (
    .clk_100(clk_100), .rst_n(rst_n), .enable(enable), .cmos_pclk(cmos_pclk),
    .cmos_href(cmos_href), .cmos_vsync(cmos_vsync), .cmos_db(cmos_db),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr0), .fifo_data(fifo_data0),
    .frame_done(frame_done0), .frame_count(frame_count0),
    .drop_count(drop_count0), .busy(busy0)
  );

  cmos_pixel_capture #(.H_DECIM(2), .V_DECIM(2)) u1 (
    .clk_100(clk_100), .rst_n(rst_n), .enable(enable), .cmos_pclk(cmos_pclk),
    .cmos_href(cmos_href), .cmos_vsync(cmos_vsync), .cmos_db(cmos_db),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr1), .fifo_data(fifo_data1),
    .frame_done(frame_done1), .frame_count(frame_count1),
    .drop_count(drop_count1), .busy(busy1)
  );

  always #5 clk_100 = ~clk_100;

  always @(negedge clk_100) begin
    cyc++;
    if (fifo_wr0) begin
      if (nw0 < 256) w0[nw0] = fifo_data0;
      nw0++;
    end
    if (fifo_wr1) begin
      if (nw1 < 256) w1[nw1] = fifo_data1;
      nw1++;
    end
    if (frame_done0) begin
      fd0++;
      fd_cyc = cyc;
    end
    if (busy_prev && !busy0) bf_cyc = cyc;
    busy_prev = busy0;
  end

  function automatic logic [7:0] bval(input int i);
    return 8'(32'h12 + 32'h22 * i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] b);
    cmos_db   = b;
    cmos_href = 1'b1;
    #40 cmos_pclk = 1'b1;
    #40 cmos_pclk = 1'b0;
  endtask

  task automatic send_line(input int start, input int nbeats);
    for (int i = 0; i < nbeats; i++) beat(bval(start + i));
    cmos_href = 1'b0;
    #200;
  endtask

  task automatic frame_start();
    cmos_vsync = 1'b0;
    #200;
  endtask

  task automatic frame_end();
    cmos_vsync = 1'b1;
    #300;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; cmos_pclk = 1'b0; cmos_href = 1'b0;
    cmos_vsync = 1'b1; cmos_db = '0; fifo_full = 1'b0;
    #23;
    chk("rst_fifo_wr", 32'(fifo_wr0), 32'd0);
    chk("rst_fifo_data", 32'(fifo_data0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_frame_count", 32'(frame_count0), 32'd0);
    chk("rst_drop_count", 32'(drop_count0), 32'd0);
    rst_n = 1'b1; enable = 1'b1;
    #100;
    chk("busy_wait_vs", 32'(busy0), 32'd1);

    // Basic 2-line x 4-pixel frame
    base0 = nw0;
    frame_start();
    send_line(0, 8);
    send_line(8, 8);
    frame_end();
    chk("t1_writes", 32'(nw0 - base0), 32'd8);
    chk("t1_px0", 32'(w0[base0]), 32'h31234);
    chk("t1_px1", 32'(w0[base0+1]), 32'h05678);
    chk("t1_px4_sol", 32'(w0[base0+4]), 32'h12244);
    chk("t1_px7", 32'(w0[base0+7]), 32'h0EE10);
    chk("t1_frame_count", 32'(frame_count0), 32'd1);
    chk("t1_frame_done", 32'(fd0), 32'd1);

    // 4x4 frame, decimated instance keeps cols 0,2 of lines 0,2
    base0 = nw0; base1 = nw1;
    frame_start();
    for (int l = 0; l < 4; l++) send_line(l * 8, 8);
    frame_end();
    chk("t2_full_writes", 32'(nw0 - base0), 32'd16);
    chk("t2_dec_writes", 32'(nw1 - base1), 32'd4);
    chk("t2_dec_px0", 32'(w1[base1]), 32'h31234);
    chk("t2_dec_px1", 32'(w1[base1+1]), 32'h09ABC);
    chk("t2_dec_px2", 32'(w1[base1+2]), 32'h13254);
    chk("t2_dec_px3", 32'(w1[base1+3]), 32'h0BADC);
    chk("t2_frame_count", 32'(frame_count0), 32'd2);

    // FIFO full for the first 3 pixels
    base0 = nw0;
    fifo_full = 1'b1;
    frame_start();
    for (int i = 0; i < 6; i++) beat(bval(i));
    fifo_full = 1'b0;
    for (int i = 6; i < 8; i++) beat(bval(i));
    cmos_href = 1'b0;
    #200;
    frame_end();
    chk("t3_drop_count", 32'(drop_count0), 32'd3);
    chk("t3_writes", 32'(nw0 - base0), 32'd1);
    chk("t3_px_sof_sol", 32'(w0[base0]), 32'h3DE00);

    // Partial pixel at line end is discarded
    base0 = nw0;
    frame_start();
    send_line(0, 3);
    send_line(3, 4);
    frame_end();
    chk("t4_writes", 32'(nw0 - base0), 32'd3);
    chk("t4_px0", 32'(w0[base0]), 32'h31234);
    chk("t4_line2_px0", 32'(w0[base0+1]), 32'h1789A);
    chk("t4_line2_px1", 32'(w0[base0+2]), 32'h0BCDE);
    chk("t4_drop_count", 32'(drop_count0), 32'd3);

    // Reset mid-line, released mid-frame
    frame_start();
    for (int i = 0; i < 3; i++) beat(bval(i));
    rst_n = 1'b0;
    #20;
    chk("t5_rst_busy", 32'(busy0), 32'd0);
    chk("t5_rst_frame_count", 32'(frame_count0), 32'd0);
    chk("t5_rst_drop_count", 32'(drop_count0), 32'd0);
    chk("t5_rst_fifo_wr", 32'(fifo_wr0), 32'd0);
    rst_n = 1'b1;
    base0 = nw0;
    for (int i = 3; i < 6; i++) beat(bval(i));
    cmos_href = 1'b0;
    #200;
    send_line(8, 8);
    chk("t5_busy_wait", 32'(busy0), 32'd1);
    frame_end();
    chk("t5_no_writes", 32'(nw0 - base0), 32'd0);
    chk("t5_frame_count", 32'(frame_count0), 32'd0);
    chk("t5_drop_count", 32'(drop_count0), 32'd0);
    frame_start();
    send_line(0, 4);
    frame_end();
    chk("t5_new_writes", 32'(nw0 - base0), 32'd2);
    chk("t5_new_px0", 32'(w0[base0]), 32'h31234);
    chk("t5_new_frame_count", 32'(frame_count0), 32'd1);

    // Enable cleared mid-frame: frame completes, then block idles
    base0 = nw0; fdb = fd0;
    frame_start();
    send_line(0, 8);
    enable = 1'b0;
    send_line(8, 8);
    frame_end();
    chk("t6_writes", 32'(nw0 - base0), 32'd8);
    chk("t6_frame_done_once", 32'(fd0 - fdb), 32'd1);
    chk("t6_busy_fall_cycle", 32'(bf_cyc), 32'(fd_cyc + 1));
    chk("t6_busy_low", 32'(busy0), 32'd0);
    chk("t6_frame_count", 32'(frame_count0), 32'd2);
    frame_start();
    send_line(0, 8);
    frame_end();
    chk("t6_idle_no_writes", 32'(nw0 - base0), 32'd8);
    chk("t6_idle_no_frame", 32'(fd0 - fdb), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
